// File: rtl/fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side consumer of an asynchronous FIFO, entirely in the clk_rd domain.
//   Issues FIFO reads, captures the returned words into a 3-entry in-order
//   buffer and re-presents them on a valid/ready stream at one word per cycle.
//   The read decision uses only registered state and FIFO/control inputs, so
//   there is no combinational path from out_ready to rd_en.
//
// Ports
//   clk_rd      read-domain clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   enable      1 = allowed to issue new FIFO reads
//   clear       synchronous flush of buffer, in-flight read and count
//   empty       FIFO empty flag
//   data_out    FIFO read data, valid the cycle after an accepted rd_en
//   rd_en       FIFO read request
//   out_valid   out_data holds a valid word
//   out_ready   downstream accepts the word this cycle
//   out_data    head-of-buffer word (registered)
//   xfer_count  completed out_valid && out_ready transfers, wraps
// ----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_rd,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    // Buffer occupancy; the encoding equals the number of stored words.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        THREE = 2'd3
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  run_q;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [DATA_WIDTH-1:0] buf_d [3];
    logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;

    logic                  push;
    logic                  pop;
    logic [1:0]            wr_idx;
    logic [2:0]            pending;

    // Words already committed: buffered plus the one returning this cycle.
    // Allowing a read only while pending <= 2 guarantees the buffer can
    // absorb every word that is requested, even under full backpressure.
    assign pending   = 3'(occ_q) + 3'(inflight_q);

    // run_q keeps rd_en low while rst_n is asserted and for the first cycle
    // after release, so no read is requested from a reset state.
    assign rd_en     = run_q && enable && !clear && !empty && (pending <= 3'd2);

    assign out_valid = (occ_q != EMPTY);
    assign out_data  = buf_q[0];
    assign xfer_count = xfer_count_q;

    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        push         = inflight_q;
        pop          = out_valid && out_ready;
        // Slot for the incoming word: just behind the current tail, shifted
        // down by one when the head leaves in the same cycle.
        wr_idx       = 2'(occ_q) - {1'b0, pop};
        buf_d        = buf_q;
        occ_d        = occ_q;
        inflight_d   = rd_en;
        xfer_count_d = xfer_count_q + CNT_WIDTH'(pop);

        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end

        // A word returning during clear is dropped on purpose.
        if (push && !clear && (wr_idx != 2'd3)) begin
            buf_d[wr_idx] = data_out;
        end

        if (clear) begin
            occ_d        = EMPTY;
            xfer_count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   occ_d = occ_e'(2'(occ_q) + 2'd1);
                2'b01:   occ_d = occ_e'(2'(occ_q) - 2'd1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= EMPTY;
            inflight_q   <= 1'b0;
            run_q        <= 1'b0;
            xfer_count_q <= '0;
            // NOTE: the buffer storage is reset because its head entry is
            // out_data, which must read zero coming out of reset.
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            run_q        <= 1'b1;
            xfer_count_q <= xfer_count_d;
            buf_q        <= buf_d;
        end
    end

endmodule
